// File: rtl/vga_pkg.sv
// Raster timing and colour constants shared by the VGA timing generator and
// the frame-buffer arbiter.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int COLOR_W      = 12;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding pending frame-buffer writes.
// The head entry is presented combinationally.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so the FIFO stays consistent on misuse.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = store[rd_ptr];

endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares a single-port frame-buffer RAM between VGA scan-out reads (priority on
// pixel strobes) and queued draw writes, upscaling cells onto the raster.
module vram_scan_arbiter #(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int COLOR_W     = vga_pkg::COLOR_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               de,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pix_color,
  output logic               vblank,
  output logic               frame_start,
  output logic               err_oob
);

  localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int                FIFO_W   = ADDR_W + COLOR_W;
  localparam logic [9:0]        H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
  localparam logic [ADDR_W:0]   FB_CELLS = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);

  logic               act_p0;
  logic               rd_slot_p0;
  logic               wr_slot_p0;
  logic [ADDR_W-1:0]  cell_x_p0;
  logic [ADDR_W-1:0]  cell_y_p0;
  logic [ADDR_W-1:0]  rd_addr_p0;
  logic               push;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [FIFO_W-1:0]  head;
  logic [ADDR_W-1:0]  head_addr;
  logic [COLOR_W-1:0] head_data;
  logic               head_ok;
  logic               ready_q;
  logic               vld_p1;
  logic               rd_p1;

  // p0: slot decision; reads win, writes take any other cycle
  assign act_p0     = de && (pixel_x < H_LIM) && (pixel_y < V_LIM);
  assign rd_slot_p0 = !reset && pix_ce && act_p0;
  assign wr_slot_p0 = !reset && !rd_slot_p0 && !empty;

  assign cell_x_p0  = ADDR_W'(pixel_x >> SCALE_SHIFT);
  assign cell_y_p0  = ADDR_W'(pixel_y >> SCALE_SHIFT);
  assign rd_addr_p0 = cell_y_p0 * FB_W_A + cell_x_p0;

  assign {head_addr, head_data} = head;
  assign head_ok = ({1'b0, head_addr} < FB_CELLS);

  // Out-of-range heads are still popped, but never reach the RAM.
  assign mem_we    = wr_slot_p0 && head_ok;
  assign mem_en    = rd_slot_p0 || mem_we;
  assign mem_addr  = rd_slot_p0 ? rd_addr_p0 : (mem_we ? head_addr : '0);
  assign mem_wdata = mem_we ? head_data : '0;

  assign wr_ready  = ready_q && !reset;
  assign push      = wr_valid && wr_ready;
  assign count_nxt = count + CW'(push) - CW'(wr_slot_p0);

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({wr_addr, wr_data}),
    .pop   (wr_slot_p0),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // p1: read or blank in flight; RAM data is valid this cycle, lands in p2
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b1;
      vld_p1      <= 1'b0;
      rd_p1       <= 1'b0;
      pix_color   <= '0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      ready_q     <= (count_nxt != CW'(FIFO_DEPTH));
      vld_p1      <= pix_ce;
      rd_p1       <= rd_slot_p0;
      if (vld_p1) pix_color <= rd_p1 ? mem_rdata : '0;
      vblank      <= (pixel_y >= V_LIM);
      frame_start <= pix_ce && (pixel_x == '0) && (pixel_y == V_LIM);
      if (wr_slot_p0 && !head_ok) err_oob <= 1'b1;
    end
  end

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter: RAM accesses are scoreboarded by a
// negedge monitor, pixel/status outputs are checked at fixed latencies.
module tb_vram_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        de;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] pix_color;
  logic        vblank;
  logic        frame_start;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [14:0] addr;
    logic [11:0] data;
  } wexp_t;

  wexp_t       wq[$];
  logic [14:0] rq[$];

  vram_scan_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .de          (de),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pix_color   (pix_color),
    .vblank      (vblank),
    .frame_start (frame_start),
    .err_oob     (err_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM access monitor: every access must match the head of its queue.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e.addr));
          chk("write_data", 32'(mem_wdata), 32'(e.data));
        end
      end else begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: addr %0d, none expected", mem_addr);
        end else begin
          logic [14:0] ea;
          ea = rq.pop_front();
          chk("read_addr", 32'(mem_addr), 32'(ea));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    // Reset held with a write request pending
    reset = 1'b1; pix_ce = 1'b0; de = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 12'h777; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_pix_color", 32'(pix_color), 0);
    chk("rst_vblank", 32'(vblank), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_err_oob", 32'(err_oob), 0);
    step(); reset = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(wr_ready), 1);
    repeat (3) step();

    // Single read: cell (2,1) -> 162, colour 2 clocks later, held
    step(); pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd8; pixel_y = 10'd4;
    rq.push_back(15'd162);
    step(); pix_ce = 1'b0; mem_rdata = 12'hABC;
    @(negedge clk); chk("pix_before_n2", 32'(pix_color), 0);
    step(); mem_rdata = 12'h000;
    @(negedge clk); chk("pix_at_n2", 32'(pix_color), 32'h0ABC);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk); chk("pix_hold", 32'(pix_color), 32'h0ABC);
    end

    // Push alongside a read slot; write follows in the next free cycle
    step(); pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd12; pixel_y = 10'd0;
    wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'h123;
    chk("ready_t3", 32'(wr_ready), 1);
    rq.push_back(15'd3);
    wq.push_back(wexp_t'{15'd5, 12'h123});
    step(); pix_ce = 1'b0; wr_valid = 1'b0; mem_rdata = 12'h5A5;
    step(); mem_rdata = 12'h000;
    @(negedge clk); chk("pix_t3", 32'(pix_color), 32'h05A5);

    // Reads every cycle starve writes; FIFO fills after 4 pushes
    for (int i = 0; i < 6; i++) begin
      step(); pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0;
      wr_valid = 1'b1; wr_addr = 15'(20 + i); wr_data = 12'(12'h200 + i);
      rq.push_back(15'd0);
      chk("ready_fill", 32'(wr_ready), (i < 4) ? 1 : 0);
      if (i < 4) wq.push_back(wexp_t'{15'(20 + i), 12'(12'h200 + i)});
    end
    step(); pix_ce = 1'b0; wr_valid = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("ready_drained", 32'(wr_ready), 1);
    chk("drain_all_written", 32'(wq.size()), 0);

    // Out-of-range write followed by the last valid cell
    step(); wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF;
    chk("ready_oob", 32'(wr_ready), 1);
    step(); wr_addr = 15'd19199; wr_data = 12'h0AA;
    chk("ready_after_oob", 32'(wr_ready), 1);
    wq.push_back(wexp_t'{15'd19199, 12'h0AA});
    @(negedge clk); chk("oob_not_yet", 32'(err_oob), 0);
    step(); wr_valid = 1'b0;
    @(negedge clk); chk("oob_set", 32'(err_oob), 1);
    repeat (3) step();
    @(negedge clk); chk("oob_sticky", 32'(err_oob), 1);

    // Bottom of frame: last active row, then first blank row
    step(); pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd0; pixel_y = 10'd479;
    rq.push_back(15'd19040);
    step(); pix_ce = 1'b1; de = 1'b0; pixel_y = 10'd480; mem_rdata = 12'h3C3;
    @(negedge clk);
    chk("vblank_479", 32'(vblank), 0);
    chk("frame_start_early", 32'(frame_start), 0);
    step(); pix_ce = 1'b0; mem_rdata = 12'h000;
    @(negedge clk);
    chk("pix_row479", 32'(pix_color), 32'h03C3);
    chk("frame_start_pulse", 32'(frame_start), 1);
    chk("vblank_480", 32'(vblank), 1);
    step();
    @(negedge clk);
    chk("frame_start_1clk", 32'(frame_start), 0);
    chk("vblank_hold", 32'(vblank), 1);
    chk("pix_blank_row", 32'(pix_color), 0);

    // de high but x beyond the active width must blank
    step(); pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd4; pixel_y = 10'd0;
    rq.push_back(15'd1);
    step(); pix_ce = 1'b0; mem_rdata = 12'h456;
    step(); mem_rdata = 12'h000; pix_ce = 1'b1; de = 1'b1; pixel_x = 10'd640;
    @(negedge clk);
    chk("pix_before_x640", 32'(pix_color), 32'h0456);
    chk("vblank_clear", 32'(vblank), 0);
    step(); pix_ce = 1'b0;
    @(negedge clk); chk("pix_x640_hold", 32'(pix_color), 32'h0456);
    step();
    @(negedge clk); chk("pix_x640_blank", 32'(pix_color), 0);

    // Only reset clears the sticky error
    step(); reset = 1'b1;
    step();
    @(negedge clk);
    chk("oob_cleared", 32'(err_oob), 0);
    chk("ready_in_reset", 32'(wr_ready), 0);
    chk("pix_reset", 32'(pix_color), 0);
    step(); reset = 1'b0;
    repeat (2) step();

    chk("reads_all_seen", 32'(rq.size()), 0);
    chk("writes_all_seen", 32'(wq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
